// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

   localparam int BIN_W_DEF  = 13;
   localparam int DIGITS_DEF = 4;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : bin_to_bcd_seq_pkg

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   always_comb begin
      nib_o = nib_i;
      if (nib_i >= 4'd5) begin
         nib_o = nib_i + 4'd3;
      end
   end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one iteration per clock, BIN_W iterations
// per conversion, result published in a single-cycle DONE state.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int BIN_W  = BIN_W_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);

   localparam int SW = DIGITS * 4;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [SW-1:0]     scratch_q;
   logic [BIN_W-1:0]  shift_q;
   logic              busy_q;
   logic              done_q;
   logic [SW-1:0]     bcd_q;

   logic [SW-1:0]     adj;
   logic [SW-1:0]     scratch_d;
   logic [BIN_W-1:0]  shift_d;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .nib_i (scratch_q[gi*4 +: 4]),
            .nib_o (adj[gi*4 +: 4])
         );
      end
   endgenerate

   // Correct all digits first, then shift the combined {scratch, shift} word.
   assign {scratch_d, shift_d} = {adj[SW-2:0], shift_q, 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         scratch_q <= '0;
         shift_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  shift_q   <= bin;
                  scratch_q <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scratch_q <= scratch_d;
               shift_q   <= shift_d;
               if (cnt_q == LAST_ITER) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  bcd_q   <= scratch_d;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: driver queues expected results and done
// timing, an independent monitor checks every cycle.
module tb_bin_to_bcd_seq;

   localparam int BIN_W  = 13;
   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [12:0] bin;
   logic        busy;
   logic        done;
   logic [15:0] bcd;

   typedef struct {
      logic [15:0] bcd;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          last_accept = -1;
   logic [15:0] hold_bcd = 16'h0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Reference: decimal digits by plain arithmetic.
   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      int          x;
      r = 16'h0;
      x = v;
      for (int d = 0; d < 4; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: busy window, done timing and value, bcd stability between results.
   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_busy;
         exp_t e;
         exp_busy = (last_accept >= 0) && (cyc >= last_accept) && (cyc <= last_accept + 12);
         chk("busy", {31'b0, busy}, {31'b0, exp_busy});
         if (done) begin
            if (sb_q.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("bcd", {16'b0, bcd}, {16'b0, e.bcd});
               hold_bcd = e.bcd;
            end
         end else begin
            if (sb_q.size() != 0 && sb_q[0].cyc <= cyc)
               chk("missing_done", 32'd0, 32'd1);
            chk("bcd_hold", {16'b0, bcd}, {16'b0, hold_bcd});
         end
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy || done) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 60) chk("drain_timeout", 32'd1, 32'd0);
      // leave the DUT in IDLE
      @(posedge clk);
      #1;
   endtask

   // Issue one accepted conversion from IDLE and queue its expectations.
   task automatic issue(input int v);
      exp_t e;
      bin   = 13'(v);
      start = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      last_accept = cyc;
      e.bcd       = ref_bcd(v);
      e.cyc       = cyc + 13;
      sb_q.push_back(e);
   endtask

   task automatic run(input int v);
      issue(v);
      wait_drain();
      $display("conv bin=%0d expected bcd=%04h", v, ref_bcd(v));
   endtask

   initial begin
      exp_t e;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_bcd", {16'b0, bcd}, 32'd0);

      // rst and start together: must stay idle
      start = 1'b1;
      bin   = 13'd77;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_start_busy", {31'b0, busy}, 32'd0);
      mon_en = 1'b1;

      // directed values and digit boundaries
      run(1234);
      run(8191);
      run(0);
      run(9);
      run(10);
      run(99);
      run(100);
      run(999);
      run(1000);
      run(5555);

      // second start during SHIFT with different bin is ignored
      issue(4095);
      repeat (4) @(posedge clk);
      #1;
      bin   = 13'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();
      $display("ignored restart, expected bcd=4095");

      // reset at E6 aborts conversion
      bin   = 13'd3210;
      start = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      last_accept = cyc;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      last_accept = -1;
      hold_bcd    = 16'h0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_bcd", {16'b0, bcd}, 32'd0);
      $display("abort by reset at E6");
      run(59);

      // start held high: accepted every 15 cycles
      bin   = 13'd100;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         last_accept = cyc;
         e.bcd = ref_bcd(100);
         e.cyc = cyc + 13;
         sb_q.push_back(e);
         if (k < 2) repeat (14) @(posedge clk);
      end
      start = 1'b0;
      wait_drain();
      $display("held start, three conversions of 100");

      // randomized values
      for (int i = 0; i < 150; i++) begin
         run(int'($urandom_range(0, 8191)));
      end

      repeat (20) @(posedge clk);
      #1;
      chk("queue_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bin_to_bcd_seq
